// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// imem_fetch_ctrl : PC sequencing and 2-entry fetch queue for the imem.
// Revision 1.0    : initial release
// ============================================================================
module imem_fetch_ctrl #(
   parameter int          DEPTH    = 128,
   parameter int          AW       = 7,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [AW-1:0] o_imem_addr,
   input  logic [31:0]   i_imem_rdata,
   input  logic          i_redirect,
   input  logic [31:0]   i_redirect_pc,
   input  logic          i_halt_req,
   output logic [31:0]   o_inst,
   output logic [31:0]   o_inst_pc,
   output logic          o_inst_valid,
   input  logic          i_inst_ready,
   output logic          o_halted,
   output logic          o_fault,
   output logic [31:0]   o_fault_pc
);

   localparam logic [31:0] c_DEPTH = 32'(DEPTH);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_q_word [2];
   logic [31:0] r_q_pc   [2];
   logic [1:0]  r_count;
   logic        r_fault;
   logic [31:0] r_fault_pc;

   logic w_pc_legal;
   logic w_pop;
   logic w_redirect;
   logic w_try_fetch;
   logic w_fault_now;
   logic w_push;
   logic w_wr_idx;

   assign w_pc_legal  = (r_pc[1:0] == 2'b00) && ({2'b00, r_pc[31:2]} < c_DEPTH);
   assign w_pop       = (r_count != 2'd0) && i_inst_ready;
   // A redirect in FAULT is dropped entirely: no flush, no pc load.
   assign w_redirect  = i_redirect && (r_state != ST_FAULT);
   assign w_try_fetch = (r_state != ST_FAULT) && !i_halt_req && !w_redirect;
   assign w_fault_now = !w_redirect && !w_pc_legal &&
                        ((r_state == ST_RUN) || ((r_state == ST_HALT) && !i_halt_req));
   assign w_push      = w_try_fetch && w_pc_legal && ((r_count != 2'd2) || w_pop);
   // New word lands at slot (count - pop); the head is always slot 0.
   assign w_wr_idx    = (r_count == 2'd2) || ((r_count == 2'd1) && !w_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_RUN;
         r_pc       <= RESET_PC;
         r_count    <= 2'd0;
         r_fault    <= 1'b0;
         r_fault_pc <= 32'd0;
         for (int i = 0; i < 2; i++) begin
            r_q_word[i] <= 32'd0;
            r_q_pc[i]   <= 32'd0;
         end
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_fault_now)
                  r_state <= ST_FAULT;
               else if (!w_redirect && i_halt_req)
                  r_state <= ST_HALT;
            end
            ST_HALT: begin
               if (w_fault_now)
                  r_state <= ST_FAULT;
               else if (!w_redirect && !i_halt_req)
                  r_state <= ST_RUN;
            end
            default: r_state <= ST_FAULT;
         endcase

         if (w_fault_now) begin
            r_fault    <= 1'b1;
            r_fault_pc <= r_pc;
         end

         if (w_redirect)
            r_pc <= i_redirect_pc;
         else if (w_push)
            r_pc <= r_pc + 32'd4;

         if (w_redirect) begin
            r_count <= 2'd0;
         end else begin
            if (w_pop) begin
               r_q_word[0] <= r_q_word[1];
               r_q_pc[0]   <= r_q_pc[1];
            end
            if (w_push) begin
               r_q_word[w_wr_idx] <= i_imem_rdata;
               r_q_pc[w_wr_idx]   <= r_pc;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
         end
      end
   end

   assign o_imem_addr  = r_pc[AW+1:2];
   assign o_inst       = r_q_word[0];
   assign o_inst_pc    = r_q_pc[0];
   assign o_inst_valid = (r_count != 2'd0);
   assign o_halted     = (r_state == ST_HALT) && (r_count == 2'd0);
   assign o_fault      = r_fault;
   assign o_fault_pc   = r_fault_pc;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_imem_fetch_ctrl : directed self-checking bench for imem_fetch_ctrl.
// Revision 1.0       : initial release
// ============================================================================
module tb_imem_fetch_ctrl;

   localparam int DEPTH = 128;
   localparam int AW    = 7;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_rdata;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          halt_req;
   logic [31:0]   inst;
   logic [31:0]   inst_pc;
   logic          inst_valid;
   logic          inst_ready;
   logic          halted;
   logic          fault;
   logic [31:0]   fault_pc;

   logic [31:0] mem [DEPTH];
   int total = 0;
   int bad   = 0;

   assign imem_rdata = mem[imem_addr];

   always #5 clk = ~clk;

   imem_fetch_ctrl #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(32'h0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .o_imem_addr  (imem_addr),
      .i_imem_rdata (imem_rdata),
      .i_redirect   (redirect),
      .i_redirect_pc(redirect_pc),
      .i_halt_req   (halt_req),
      .o_inst       (inst),
      .o_inst_pc    (inst_pc),
      .o_inst_valid (inst_valid),
      .i_inst_ready (inst_ready),
      .o_halted     (halted),
      .o_fault      (fault),
      .o_fault_pc   (fault_pc)
   );

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hold reset for one edge with the given ready level, then release.
   task automatic do_reset(input logic rdy);
      rst_n = 1'b0; redirect = 1'b0; halt_req = 1'b0; inst_ready = rdy;
      cyc(1);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; halt_req = 1'b0; inst_ready = 1'b1;
      cyc(2);
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
      total++; if (inst !== 32'd0) begin bad++; $display("FAIL reset_inst got=%h exp=0", inst); end
      total++; if (inst_pc !== 32'd0) begin bad++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
      total++; if (fault_pc !== 32'd0) begin bad++; $display("FAIL reset_fault_pc got=%h exp=0", fault_pc); end
      total++; if (imem_addr !== 7'd0) begin bad++; $display("FAIL reset_imem_addr got=%0d exp=0", imem_addr); end
   endtask

   task automatic test_seq_fetch();
      logic [31:0] exp_w [4];
      exp_w = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, inst_valid); end
         total++; if (inst_pc !== 32'(4*i)) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, inst_pc, 32'(4*i)); end
         total++; if (inst !== exp_w[i]) begin bad++; $display("FAIL seq_inst[%0d] got=%h exp=%h", i, inst, exp_w[i]); end
      end
   endtask

   task automatic test_backpressure();
      do_reset(1'b0);
      cyc(5);
      total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", inst_valid); end
      total++; if (inst !== 32'h0000_0013) begin bad++; $display("FAIL bp_inst got=%h exp=00000013", inst); end
      total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL bp_inst_pc got=%h exp=0", inst_pc); end
      total++; if (imem_addr !== 7'd2) begin bad++; $display("FAIL bp_imem_addr got=%0d exp=2", imem_addr); end
      inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++; if (inst_pc !== 32'(4*i)) begin bad++; $display("FAIL bp_order_pc[%0d] got=%h exp=%h", i, inst_pc, 32'(4*i)); end
         total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL bp_order_valid[%0d] got=%b exp=1", i, inst_valid); end
         cyc(1);
      end
   endtask

   task automatic test_redirect();
      do_reset(1'b0);
      cyc(3);
      total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL rd_pre_pc got=%h exp=0", inst_pc); end
      redirect = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b1;
      cyc(1);
      redirect = 1'b0;
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rd_bubble got=%b exp=0", inst_valid); end
      cyc(1);
      total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL rd_tgt_valid got=%b exp=1", inst_valid); end
      total++; if (inst_pc !== 32'h40) begin bad++; $display("FAIL rd_tgt_pc got=%h exp=00000040", inst_pc); end
      total++; if (inst !== 32'hA500_0010) begin bad++; $display("FAIL rd_tgt_inst got=%h exp=a5000010", inst); end
      cyc(1);
      total++; if (inst_pc !== 32'h44) begin bad++; $display("FAIL rd_next_pc got=%h exp=00000044", inst_pc); end
   endtask

   task automatic test_halt();
      do_reset(1'b1);
      cyc(4);
      total++; if (inst_pc !== 32'hC) begin bad++; $display("FAIL halt_pre_pc got=%h exp=0000000c", inst_pc); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_pre_halted got=%b exp=0", halted); end
      halt_req = 1'b1;
      cyc(1);
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL halt_drain_valid got=%b exp=0", inst_valid); end
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_halted got=%b exp=1", halted); end
      cyc(3);
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_hold got=%b exp=1", halted); end
      total++; if (imem_addr !== 7'd4) begin bad++; $display("FAIL halt_imem_addr got=%0d exp=4", imem_addr); end
      halt_req = 1'b0;
      cyc(1);
      total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL resume_valid got=%b exp=1", inst_valid); end
      total++; if (inst_pc !== 32'h10) begin bad++; $display("FAIL resume_pc got=%h exp=00000010", inst_pc); end
      total++; if (inst !== 32'hA500_0004) begin bad++; $display("FAIL resume_inst got=%h exp=a5000004", inst); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL resume_halted got=%b exp=0", halted); end
   endtask

   task automatic test_fault_boundary();
      do_reset(1'b0);
      cyc(1);
      redirect = 1'b1; redirect_pc = 32'h1FC;
      cyc(1);
      redirect = 1'b0;
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL fb_bubble got=%b exp=0", inst_valid); end
      cyc(1);
      total++; if (inst_pc !== 32'h1FC) begin bad++; $display("FAIL fb_last_pc got=%h exp=000001fc", inst_pc); end
      total++; if (inst !== 32'hA500_007F) begin bad++; $display("FAIL fb_last_inst got=%h exp=a500007f", inst); end
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL fb_early_fault got=%b exp=0", fault); end
      cyc(1);
      total++; if (fault !== 1'b1) begin bad++; $display("FAIL fb_fault got=%b exp=1", fault); end
      total++; if (fault_pc !== 32'h200) begin bad++; $display("FAIL fb_fault_pc got=%h exp=00000200", fault_pc); end
      total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h1FC) begin bad++; $display("FAIL fb_pending got=%b/%h exp=1/000001fc", inst_valid, inst_pc); end
      inst_ready = 1'b1;
      cyc(1);
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL fb_drained got=%b exp=0", inst_valid); end
      redirect = 1'b1; redirect_pc = 32'h20;
      cyc(1);
      redirect = 1'b0;
      cyc(2);
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL fb_no_fetch got=%b exp=0", inst_valid); end
      total++; if (imem_addr !== 7'd0) begin bad++; $display("FAIL fb_redirect_ignored got=%0d exp=0", imem_addr); end
      total++; if (fault !== 1'b1 || fault_pc !== 32'h200) begin bad++; $display("FAIL fb_sticky got=%b/%h exp=1/00000200", fault, fault_pc); end
   endtask

   task automatic test_misaligned_reset();
      do_reset(1'b1);
      cyc(2);
      redirect = 1'b1; redirect_pc = 32'h6;
      cyc(1);
      redirect = 1'b0;
      total++; if (inst_valid !== 1'b0 || fault !== 1'b0) begin bad++; $display("FAIL mis_bubble got=%b/%b exp=0/0", inst_valid, fault); end
      cyc(1);
      total++; if (fault !== 1'b1) begin bad++; $display("FAIL mis_fault got=%b exp=1", fault); end
      total++; if (fault_pc !== 32'h6) begin bad++; $display("FAIL mis_fault_pc got=%h exp=00000006", fault_pc); end
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL mis_valid got=%b exp=0", inst_valid); end
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      total++; if (fault !== 1'b0 || fault_pc !== 32'd0) begin bad++; $display("FAIL rec_fault got=%b/%h exp=0/0", fault, fault_pc); end
      cyc(1);
      total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin bad++; $display("FAIL rec_first got=%b/%h exp=1/0", inst_valid, inst_pc); end
      total++; if (inst !== 32'h0000_0013) begin bad++; $display("FAIL rec_inst got=%h exp=00000013", inst); end
      cyc(1);
      total++; if (inst_pc !== 32'h4) begin bad++; $display("FAIL rec_second got=%h exp=00000004", inst_pc); end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA500_0000 | 32'(i);
      mem[0] = 32'h0000_0013;
      mem[1] = 32'h0010_0093;
      mem[2] = 32'h0020_0113;
      mem[3] = 32'h0030_0193;
      test_reset();
      test_seq_fetch();
      test_backpressure();
      test_redirect();
      test_halt();
      test_fault_boundary();
      test_misaligned_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

endmodule
`default_nettype wire
